// File: rtl/conway_led_scanner.sv
// Purpose : snapshots the Game of Life board once per frame and scans it row by
//           row into a shift-register LED column driver (sclk/sdata/latch), with
//           one-hot row enables and a step_ena pulse every FRAMES_PER_STEP frames.
// Latency : all outputs registered; frame = 1 + ROWS*(2*CLK_DIV*COLS + 1 + DWELL) cycles.
// Backpressure: none; free-running, the column driver must keep up with sclk.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   cells         board state, cell (r,c) at bit r*COLS+c
//   sclk, sdata   serial column clock/data, column COLS-1 first
//   latch         one-cycle latch strobe after each row is shifted
//   row_sel       one-hot row enable
//   frame_done    one-cycle pulse in the last cycle of each frame
//   step_ena      one-cycle pulse every FRAMES_PER_STEP frames (to cell ena)
//
// Optional: define CONWAY_SCAN_BLANK_EN to blank row_sel outside DWELL.
module conway_led_scanner #(
  parameter int ROWS            = 8,
  parameter int COLS            = 8,
  parameter int CLK_DIV         = 4,
  parameter int DWELL           = 1000,
  parameter int FRAMES_PER_STEP = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ROWS*COLS-1:0] cells,
  output logic                 sclk,
  output logic                 sdata,
  output logic                 latch,
  output logic [ROWS-1:0]      row_sel,
  output logic                 frame_done,
  output logic                 step_ena
);

  localparam int N     = ROWS * COLS;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DWL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int FRM_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DWL_W-1:0] DWL_LAST = DWL_W'(DWELL - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAMES_PER_STEP - 1);

  typedef enum logic [1:0] {S_SNAPSHOT, S_SHIFT, S_LATCH, S_DWELL} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     snap_q;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DWL_W-1:0] dwell_q, dwell_d;
  logic [FRM_W-1:0] frame_q, frame_d;
  logic             sclk_d, sdata_d, latch_d, frame_done_d, step_ena_d;
  logic [ROWS-1:0]  row_sel_d;

  // Snapshot bit indices for the next column of this row and for the first
  // column of the following row; only used on the branches where they are valid.
  logic [IDX_W-1:0] idx_next_col, idx_next_row;
  assign idx_next_col = IDX_W'(int'(row_q) * COLS + int'(col_q) - 1);
  assign idx_next_row = IDX_W'((int'(row_q) + 1) * COLS + COLS - 1);

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    div_d     = div_q;
    dwell_d   = dwell_q;
    sclk_d    = sclk;
    sdata_d   = sdata;
    latch_d   = 1'b0;
`ifdef CONWAY_SCAN_BLANK_EN
    row_sel_d = '0;
`else
    row_sel_d = row_sel;
`endif
    case (state_q)
      S_SNAPSHOT: begin
        // sdata must be valid on entry to SHIFT while snap_q is still loading,
        // so the first bit comes straight from cells into the sdata flop.
        state_d = S_SHIFT;
        row_d   = '0;
        col_d   = COL_LAST;
        div_d   = '0;
        sclk_d  = 1'b0;
        sdata_d = cells[COLS-1];
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (col_q == '0) begin
              state_d = S_LATCH;
              latch_d = 1'b1;
            end else begin
              col_d   = col_q - COL_W'(1);
              sdata_d = snap_q[idx_next_col];
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_LATCH: begin
        state_d   = S_DWELL;
        dwell_d   = '0;
        row_sel_d = ROWS'(1) << row_q;
      end
      S_DWELL: begin
        if (dwell_q == DWL_LAST) begin
          if (row_q == ROW_LAST) begin
            state_d = S_SNAPSHOT;
          end else begin
            state_d = S_SHIFT;
            row_d   = row_q + ROW_W'(1);
            col_d   = COL_LAST;
            div_d   = '0;
            sclk_d  = 1'b0;
            sdata_d = snap_q[idx_next_row];
          end
        end else begin
          dwell_d   = dwell_q + DWL_W'(1);
          row_sel_d = row_sel;
        end
      end
      default: state_d = S_SNAPSHOT;
    endcase

    // Look ahead: frame_done/step_ena are registered, so they are raised on the
    // edge that enters the final DWELL cycle of the last row.
    frame_done_d = (state_d == S_DWELL) && (dwell_d == DWL_LAST) && (row_d == ROW_LAST);
    step_ena_d   = frame_done_d && (frame_q == FRM_LAST);
    frame_d      = frame_q;
    if (frame_done_d) frame_d = (frame_q == FRM_LAST) ? '0 : frame_q + FRM_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_SNAPSHOT;
      snap_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      div_q      <= '0;
      dwell_q    <= '0;
      frame_q    <= '0;
      sclk       <= 1'b0;
      sdata      <= 1'b0;
      latch      <= 1'b0;
      row_sel    <= '0;
      frame_done <= 1'b0;
      step_ena   <= 1'b0;
    end else begin
      state_q    <= state_d;
      if (state_q == S_SNAPSHOT) snap_q <= cells;
      row_q      <= row_d;
      col_q      <= col_d;
      div_q      <= div_d;
      dwell_q    <= dwell_d;
      frame_q    <= frame_d;
      sclk       <= sclk_d;
      sdata      <= sdata_d;
      latch      <= latch_d;
      row_sel    <= row_sel_d;
      frame_done <= frame_done_d;
      step_ena   <= step_ena_d;
    end
  end

endmodule
